// File: rtl/deser_loader.sv
// deser_loader: framed serial-to-parallel front end for a DATA_WIDTH-bit
// storage register. Bits are gathered into a shift register and the finished
// word is presented on Q with a one-cycle valid strobe V.
//
// Optional feature: define DESER_LOADER_PARITY_EN to add a trailing even-parity
// bit per frame (PAR state, PERR reported alongside V). Without the macro there
// is no PAR state and PERR is constant 0.
//
// Handshake: a bit is transferred on every rising edge of C where E=1; S=1 on
// such an edge marks that bit as frame bit 0 (restarting any frame in
// progress). V is a one-cycle strobe with no backpressure: the downstream
// register must load Q whenever V=1. B reports a partially received frame.
module deser_loader #(
  parameter int unsigned           DATA_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
  parameter bit                    MSB_FIRST  = 1'b1
) (
  input  logic                  C,
  input  logic                  R,
  input  logic                  S,
  input  logic                  E,
  input  logic                  D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  V,
  output logic                  B,
  output logic                  PERR,
  output logic [1:0]            state_dbg
);

`ifdef DESER_LOADER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  localparam logic [5:0] CNT_FULL = 6'(DATA_WIDTH);

  state_t                  state_q, state_d;
  logic [5:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   sh_q, sh_d;
  logic [DATA_WIDTH-1:0]   q_q, q_d;
  logic                    v_q, v_d;
  logic                    b_q, b_d;
  logic                    perr_q, perr_d;

  // Bit accepted this edge, the word it produces and the resulting bit count.
  logic                    accept;
  logic [DATA_WIDTH-1:0]   word_n;
  logic [5:0]              cnt_n;

  // Insert one serial bit according to the configured bit order.
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b);
    logic [DATA_WIDTH-1:0] r;
    if (MSB_FIRST) begin
      r    = w << 1;
      r[0] = b;
    end else begin
      r                 = w >> 1;
      r[DATA_WIDTH-1]   = b;
    end
    return r;
  endfunction

  // Next-state and output logic: bit capture, abort/restart and completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    q_d     = q_q;
    v_d     = 1'b0;
    perr_d  = 1'b0;
    accept  = 1'b0;
    word_n  = '0;
    cnt_n   = '0;

    case (state_q)
      IDLE: begin
        if (E && S) begin
          accept = 1'b1;
          word_n = shift_in('0, D);
          cnt_n  = 6'd1;
        end
      end
      SHIFT: begin
        if (E) begin
          accept = 1'b1;
          if (S) begin
            // Restart: the partial word is dropped, D is the new bit 0.
            word_n = shift_in('0, D);
            cnt_n  = 6'd1;
          end else begin
            word_n = shift_in(sh_q, D);
            cnt_n  = cnt_q + 6'd1;
          end
        end
      end
`ifdef DESER_LOADER_PARITY_EN
      PAR: begin
        if (E) begin
          if (S) begin
            accept = 1'b1;
            word_n = shift_in('0, D);
            cnt_n  = 6'd1;
          end else begin
            // Parity bit: the word is delivered even when the check fails.
            q_d     = sh_q;
            v_d     = 1'b1;
            perr_d  = (^sh_q) ^ D;
            sh_d    = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sh_d    = '0;
      end
    endcase

    if (accept) begin
      sh_d    = word_n;
      cnt_d   = cnt_n;
      state_d = SHIFT;
      if (cnt_n == CNT_FULL) begin
`ifdef DESER_LOADER_PARITY_EN
        state_d = PAR;
`else
        q_d     = word_n;
        v_d     = 1'b1;
        sh_d    = '0;
        cnt_d   = '0;
        state_d = IDLE;
`endif
      end
    end

    b_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      q_q     <= INIT_VAL;
      v_q     <= 1'b0;
      b_q     <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      q_q     <= q_d;
      v_q     <= v_d;
      b_q     <= b_d;
      perr_q  <= perr_d;
    end
  end

  assign Q         = q_q;
  assign V         = v_q;
  assign B         = b_q;
  assign PERR      = perr_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_deser_loader.sv
// Bench for deser_loader: one MSB-first and one LSB-first instance share the
// same serial stimulus; expected words are queued per instance when a frame is
// driven and compared when V pulses.
module tb_deser_loader;
  localparam int W = 4;
  localparam logic [W-1:0] INIT_M = 4'hA;
  localparam logic [W-1:0] INIT_L = 4'h5;
`ifdef DESER_LOADER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic C = 1'b0;
  logic R, S, E, D;
  logic [W-1:0] q_m, q_l;
  logic v_m, v_l, b_m, b_l, perr_m, perr_l;
  logic [1:0] st_m, st_l;

  int n_checks = 0;
  int n_errors = 0;
  logic [W:0] exp_m_q[$];
  logic [W:0] exp_l_q[$];
  logic [W:0] e_m, e_l;

  typedef struct {
    logic [W-1:0] bits;   // bits[3] is sent first
    int           gap;
    logic [W-1:0] exp_m;
    logic [W-1:0] exp_l;
    bit           idle_after;
  } vec_t;
  vec_t tbl[6];

  deser_loader #(.DATA_WIDTH(W), .INIT_VAL(INIT_M), .MSB_FIRST(1'b1)) dut_m (
    .C(C), .R(R), .S(S), .E(E), .D(D),
    .Q(q_m), .V(v_m), .B(b_m), .PERR(perr_m), .state_dbg(st_m)
  );

  deser_loader #(.DATA_WIDTH(W), .INIT_VAL(INIT_L), .MSB_FIRST(1'b0)) dut_l (
    .C(C), .R(R), .S(S), .E(E), .D(D),
    .Q(q_l), .V(v_l), .B(b_l), .PERR(perr_l), .state_dbg(st_l)
  );

  // Clock
  always #5 C = ~C;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rev4(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  // Driver: inputs change on the falling edge, DUT samples on the rising edge.
  task automatic step(input logic s, input logic e, input logic d);
    S = s; E = e; D = d;
    @(negedge C);
  endtask

  task automatic send_frame(input logic [W-1:0] bits, input int gap, input logic pbit,
                            input logic [W-1:0] xm, input logic [W-1:0] xl,
                            input logic xperr);
    exp_m_q.push_back({xperr, xm});
    exp_l_q.push_back({xperr, xl});
    for (int i = W - 1; i >= 0; i--) begin
      step(i == W - 1, 1'b1, bits[i]);
      if (i > 0 || PAR_EN) repeat (gap) step(1'b0, 1'b0, 1'b0);
    end
`ifdef DESER_LOADER_PARITY_EN
    step(1'b0, 1'b1, pbit);
`endif
  endtask

  // Scoreboard: every V pulse must match the oldest queued frame.
  always @(negedge C) begin
    if (!R) begin
      if (v_m) begin
        if (exp_m_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL v_m: unexpected pulse, q=%0h", q_m);
        end else begin
          e_m = exp_m_q.pop_front();
          check("q_m", q_m, e_m[W-1:0]);
          check("perr_m", perr_m, e_m[W]);
        end
      end
      if (v_l) begin
        if (exp_l_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL v_l: unexpected pulse, q=%0h", q_l);
        end else begin
          e_l = exp_l_q.pop_front();
          check("q_l", q_l, e_l[W-1:0]);
          check("perr_l", perr_l, e_l[W]);
        end
      end
`ifndef DESER_LOADER_PARITY_EN
      if (perr_m !== 1'b0 || perr_l !== 1'b0) begin
        n_checks++; n_errors++;
        $display("FAIL perr_const: got %b/%b expected 0", perr_m, perr_l);
      end
`endif
    end
  end

  initial begin
    logic [W-1:0] bits;
    logic pb;
    int g;

    tbl[0] = '{4'b1100, 0, 4'b1100, 4'b0011, 1'b0};
    tbl[1] = '{4'b0101, 0, 4'b0101, 4'b1010, 1'b1};
    tbl[2] = '{4'b0000, 1, 4'b0000, 4'b0000, 1'b1};
    tbl[3] = '{4'b1111, 0, 4'b1111, 4'b1111, 1'b0};
    tbl[4] = '{4'b1000, 3, 4'b1000, 4'b0001, 1'b1};
    tbl[5] = '{4'b0110, 0, 4'b0110, 4'b0110, 1'b1};

    // Reset
    R = 1'b1; S = 1'b0; E = 1'b0; D = 1'b0;
    repeat (2) @(negedge C);
    check("rst_q_m", q_m, INIT_M);
    check("rst_q_l", q_l, INIT_L);
    check("rst_v_m", v_m, 1'b0);
    check("rst_b_m", b_m, 1'b0);
    check("rst_perr_m", perr_m, 1'b0);
    check("rst_state_m", st_m, 2'd0);
    R = 1'b0;
    @(negedge C);

    // Gapped frame 1,0,1,1: Q holds INIT_VAL until completion
    bits = 4'b1011;
    exp_m_q.push_back({1'b0, 4'b1011});
    exp_l_q.push_back({1'b0, 4'b1101});
    for (int i = W - 1; i >= 0; i--) begin
      step(i == W - 1, 1'b1, bits[i]);
      if (i > 0) begin
        check("hold_q_m", q_m, INIT_M);
        check("hold_q_l", q_l, INIT_L);
        repeat (2) step(1'b0, 1'b0, 1'b0);
      end
    end
`ifdef DESER_LOADER_PARITY_EN
    step(1'b0, 1'b1, 1'b1);
`endif
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // Frame 1,0,1,1 back-to-back bits: B/V timing
    exp_m_q.push_back({1'b0, 4'b1011});
    exp_l_q.push_back({1'b0, 4'b1101});
    for (int k = W - 1; k >= 0; k--) begin
      step(k == W - 1, 1'b1, bits[k]);
      check("t1_b_m", b_m, (k > 0) || PAR_EN);
      check("t1_v_m", v_m, (k == 0) && !PAR_EN);
    end
`ifdef DESER_LOADER_PARITY_EN
    step(1'b0, 1'b1, 1'b1);
    check("t1_v_par", v_m, 1'b1);
    check("t1_b_par", b_m, 1'b0);
`endif
    step(1'b0, 1'b0, 1'b0);
    check("t1_v_once", v_m, 1'b0);
    check("t1_v_once_l", v_l, 1'b0);

    // Table: back-to-back frames and gaps
    foreach (tbl[i]) begin
      send_frame(tbl[i].bits, tbl[i].gap, ^tbl[i].bits, tbl[i].exp_m, tbl[i].exp_l, 1'b0);
      if (tbl[i].idle_after) step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);

    // Abort: bits 1,1 then a restart with 0,0,0,1
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("abort_b_m", b_m, 1'b1);
    check("abort_hold_q_m", q_m, 4'b0110);
    send_frame(4'b0001, 0, 1'b1, 4'b0001, 4'b1000, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-frame
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    #2 R = 1'b1;
    #1;
    check("arst_q_m", q_m, INIT_M);
    check("arst_q_l", q_l, INIT_L);
    check("arst_b_m", b_m, 1'b0);
    check("arst_b_l", b_l, 1'b0);
    @(negedge C);
    R = 1'b0;
    @(negedge C);
    send_frame(4'b0110, 0, 1'b0, 4'b0110, 4'b0110, 1'b0);
    step(1'b0, 1'b0, 1'b0);

`ifdef DESER_LOADER_PARITY_EN
    // Parity good and bad
    send_frame(4'b1011, 0, 1'b1, 4'b1011, 4'b1101, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    send_frame(4'b1011, 0, 1'b0, 4'b1011, 4'b1101, 1'b1);
    step(1'b0, 1'b0, 1'b0);
`endif

    // Random frames
    for (int n = 0; n < 10; n++) begin
      bits = 4'($urandom_range(0, 15));
      g    = int'($urandom_range(0, 2));
      pb   = 1'($urandom_range(0, 1));
      send_frame(bits, g, pb, bits, rev4(bits), PAR_EN ? ((^bits) ^ pb) : 1'b0);
      if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, 1'b0);
    end

    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("pending_m", exp_m_q.size(), 0);
    check("pending_l", exp_l_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
